toggle_event_receiver: RTL and testbench
========================================

Name: toggle_event_receiver

Overview:
- Receive end of the toggle-signalling link whose transmit end is a preset T flip-flop chain.
- The remote sender flips a single line (TIN) once per event. This block synchronises TIN into the CP domain, detects each transition, and emits a one-cycle pulse per transition.
- It queues events in a saturating counter that a consumer drains, and returns a two-phase acknowledge toggle (ACK) per accepted event.
- A lock phase after reset rejects start-up glitches.

Parameters:
- CNT_W, 4, width of the pending-event counter (max pending = 2^CNT_W-1).
- INIT_LEVEL, 1, reset level of the synchroniser stages; matches the sender's preset state, where Q=1 after preset.
- LOCK_CYC, 4, consecutive stable synchronised cycles required before events are accepted (range 1..255).

Ports:
- CP, input, 1, clock; all state updates on rising edge.
- CD, input, 1, reset; synchronous and active-high; sampled only on rising CP.
- TIN, input, 1, asynchronous toggle line from the remote sender.
- RD, input, 1, consumer pops one pending event.
- CLR, input, 1, synchronous clear of CNT and OVF.
- PULSE, output, 1, one-cycle strobe per accepted TIN transition.
- CNT, output, CNT_W, number of pending events.
- PEND, output, 1, CNT != 0.
- OVF, output, 1, sticky overflow flag.
- ACK, output, 1, toggles once per accepted event; two-phase return to the sender.
- LOCK, output, 1, high in RUN state.

Behaviour:
- Reset (CD=1 at an edge):
  - s1, s2, s3 <= INIT_LEVEL.
  - state <= LOCKING; lock counter <= 0.
  - PULSE=0, CNT=0, PEND=0, OVF=0, ACK=0, LOCK=0.
  - Reset overrides every other input.
  - Reset asserted mid-operation discards pending events with no ACK.
- Synchroniser: each edge, s1<=TIN, s2<=s1, s3<=s2. Transition detect t = s2 XOR s3.
- State LOCKING:
  - t=1: lock counter <= 0.
  - t=0: lock counter increments.
  - When lock counter reaches LOCK_CYC-1 with t=0, go to RUN at that edge.
  - No PULSE, CNT or ACK activity in LOCKING; transitions in LOCKING are absorbed, not counted.
- State RUN:
  - LOCK=1.
  - When t=1 at an edge: PULSE<=1 for exactly one cycle and ACK<=~ACK.
  - Latency: TIN flips before edge e0, PULSE/ACK/CNT update visible after edge e2 (3 edges).
  - RUN persists until reset.
- Counter update priority per edge:
  - CLR: CNT<=0 and OVF<=0. A same-edge event still pulses and toggles ACK but is not counted; RD is ignored.
  - Event and RD with CNT>0: CNT unchanged.
  - Event only, CNT<max: CNT+1.
  - Event only, CNT=max: CNT holds max, OVF<=1.
  - Event and RD with CNT=max: CNT unchanged, no overflow.
  - RD only, CNT>0: CNT-1.
  - RD only, CNT=0: no effect; never underflows.
  - Event and RD with CNT=0: CNT<=1. RD pops nothing because it precedes arrival.
- OVF is sticky until CLR or reset.
- ACK toggles for every event detected in RUN, including overflowed or cleared ones, so the sender never stalls.
- PEND is combinational from CNT.
- All other outputs are registered.
- Back-to-back TIN flips on consecutive cycles each yield a pulse, provided each level is held at least one CP period.

Test Plan:
- Reset/lock: CD=1 for 2 edges, TIN=1 held; release CD. Required: LOCK rises after edge 4 (LOCK_CYC=4), CNT=0, ACK=0, PULSE never asserted.
- Lock restart: after reset, flip TIN at cycle 2. Required: lock counter restarts, LOCK rises 4 stable cycles after s2 settles, no PULSE, CNT=0.
- Single event: in RUN, flip TIN 1->0 before edge e0. Required: PULSE=1 only in the cycle after e2, CNT=1, PEND=1, ACK=1; RD one edge later gives CNT=0, PEND=0.
- Saturation: 17 TIN flips, RD=0, CNT_W=4. Required: CNT=15 after flip 15; OVF=1 after flip 16 and stays set; ACK toggled 17 times (ends at 1). Then CLR gives CNT=0, OVF=0.
- Simultaneous: CNT=3, event edge coincides with RD -> CNT stays 3. CNT=0, event with RD -> CNT=1. CLR with event -> CNT=0, PULSE=1, ACK toggles.
- Reset mid-run: CNT=5, OVF=1, assert CD for one edge. Required: all outputs 0 next cycle, LOCK=0, lock phase repeats before any new event is counted.

Source files
------------

// File: rtl/toggle_event_receiver.sv
// Receive end of a toggle-signalling link: synchronises TIN, turns each
// transition into a one-cycle pulse, queues it, and returns a two-phase ACK.
module toggle_event_receiver #(
  parameter int unsigned CNT_W      = 4,
  parameter bit          INIT_LEVEL = 1'b1,
  parameter int unsigned LOCK_CYC   = 4
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             TIN,
  input  logic             RD,
  input  logic             CLR,
  output logic             PULSE,
  output logic [CNT_W-1:0] CNT,
  output logic             PEND,
  output logic             OVF,
  output logic             ACK,
  output logic             LOCK
);

  typedef enum logic {LOCKING, RUN} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [7:0]       LOCK_TOP = 8'(LOCK_CYC - 1);

  state_e           state_q, state_d;
  logic [7:0]       lock_cnt_q, lock_cnt_d;
  logic             s1_q, s2_q, s3_q;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ack_q, ack_d;
  logic             t;
  logic             ev;

  assign t  = s2_q ^ s3_q;
  assign ev = (state_q == RUN) && t;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (state_q == LOCKING) begin
      if (t) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q == LOCK_TOP) begin
        state_d = RUN;
      end else begin
        lock_cnt_d = lock_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    pulse_d = ev;
    ack_d   = ack_q ^ ev;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (CLR) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (ev && RD) begin
      // A read arriving with the first event cannot pop it.
      if (cnt_q == '0) cnt_d = CNT_W'(1);
    end else if (ev) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end else if (RD && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // sample the pre-edge values, as the synchroniser chain relies on.
  always_ff @(posedge CP) begin
    if (CD) begin
      s1_q       <= INIT_LEVEL;
      s2_q       <= INIT_LEVEL;
      s3_q       <= INIT_LEVEL;
      state_q    <= LOCKING;
      lock_cnt_q <= '0;
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      s1_q       <= TIN;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      ack_q      <= ack_d;
    end
  end

  assign PULSE = pulse_q;
  assign CNT   = cnt_q;
  assign PEND  = (cnt_q != '0);
  assign OVF   = ovf_q;
  assign ACK   = ack_q;
  assign LOCK  = (state_q == RUN);

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed bench for toggle_event_receiver: expected outputs are queued as
// each TIN flip is driven and compared when the pulse is due.
module tb_toggle_event_receiver;

  logic       CP = 1'b0;
  logic       CD, TIN, RD, CLR;
  logic       PULSE, PEND, OVF, ACK, LOCK;
  logic [3:0] CNT;

  toggle_event_receiver #(.CNT_W(4), .INIT_LEVEL(1'b1), .LOCK_CYC(4)) dut (
    .CP(CP), .CD(CD), .TIN(TIN), .RD(RD), .CLR(CLR),
    .PULSE(PULSE), .CNT(CNT), .PEND(PEND), .OVF(OVF), .ACK(ACK), .LOCK(LOCK)
  );

  always #5 CP = ~CP;

  typedef struct {
    string      tag;
    logic       pulse;
    logic [3:0] cnt;
    logic       ovf;
    logic       ack;
    logic       lock;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic ack_m  = 1'b0;
  logic saw_pulse;
  logic got_lock;

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic pulse, input logic [3:0] cnt,
                      input logic ovf, input logic ack, input logic lock);
    exp_t e;
    e.tag = tag; e.pulse = pulse; e.cnt = cnt; e.ovf = ovf; e.ack = ack; e.lock = lock;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underrun", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_pulse"}, 8'(PULSE), 8'(e.pulse));
      chk({e.tag, "_cnt"},   8'(CNT),   8'(e.cnt));
      chk({e.tag, "_pend"},  8'(PEND),  8'(e.cnt != 4'd0));
      chk({e.tag, "_ovf"},   8'(OVF),   8'(e.ovf));
      chk({e.tag, "_ack"},   8'(ACK),   8'(e.ack));
      chk({e.tag, "_lock"},  8'(LOCK),  8'(e.lock));
    end
  endtask

  // Drive one TIN flip in RUN and queue the outputs it must produce.
  task automatic ev(input string tag, input int cnt_e, input logic ovf_e);
    ack_m = ~ack_m;
    push(tag, 1'b1, 4'(cnt_e), ovf_e, ack_m, 1'b1);
    TIN = ~TIN;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    CD = 1'b1; TIN = 1'b1; RD = 1'b0; CLR = 1'b0;

    // Reset and initial lock with TIN held steady.
    step(); step();
    push("rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); pop_check();
    CD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      push("lock_wait", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); pop_check();
    end
    step();
    push("locked", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); pop_check();

    // Lock restart: a flip during LOCKING delays lock and is not counted.
    CD = 1'b1; step(); step(); CD = 1'b0;
    step();
    TIN = 1'b0;
    step(); step(); step();
    push("relock_e4", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); pop_check();
    for (int i = 0; i < 3; i++) begin
      step();
      push("relock_wait", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); pop_check();
    end
    step();
    push("relock_e8", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); pop_check();
    ack_m = 1'b0;

    // Single event with 3-edge latency, then a read.
    ev("single", 1, 1'b0);
    step(); step();
    chk("single_early_pulse", 8'(PULSE), 8'd0);
    step(); pop_check();
    RD = 1'b1; step(); RD = 1'b0;
    push("single_rd", 1'b0, 4'd0, 1'b0, ack_m, 1'b1); pop_check();

    // Saturation: 17 events without reads.
    for (int i = 1; i <= 17; i++) begin
      ev("sat", (i > 15) ? 15 : i, (i >= 16));
      step(); step(); step(); pop_check();
    end
    step();
    push("sat_hold", 1'b0, 4'd15, 1'b1, ack_m, 1'b1); pop_check();
    CLR = 1'b1; step(); CLR = 1'b0;
    push("clr", 1'b0, 4'd0, 1'b0, ack_m, 1'b1); pop_check();

    // Back-to-back flips on consecutive cycles.
    ev("b2b1", 1, 1'b0); step();
    ev("b2b2", 2, 1'b0); step();
    ev("b2b3", 3, 1'b0); step(); pop_check();
    step(); pop_check();
    step(); pop_check();
    step();
    push("b2b_quiet", 1'b0, 4'd3, 1'b0, ack_m, 1'b1); pop_check();

    // Event coincident with RD at CNT=3 leaves CNT unchanged.
    ev("ev_rd_3", 3, 1'b0);
    step(); step(); RD = 1'b1; step(); RD = 1'b0; pop_check();

    // Drain to zero; an extra read must not underflow.
    RD = 1'b1;
    step(); step(); step(); step();
    RD = 1'b0;
    push("drain", 1'b0, 4'd0, 1'b0, ack_m, 1'b1); pop_check();

    // Event coincident with RD at CNT=0 gives CNT=1.
    ev("ev_rd_0", 1, 1'b0);
    step(); step(); RD = 1'b1; step(); RD = 1'b0; pop_check();

    // Event coincident with CLR pulses and toggles ACK but is not counted.
    ev("ev_clr", 0, 1'b0);
    step(); step(); CLR = 1'b1; step(); CLR = 1'b0; pop_check();

    // Fill to overflow with back-to-back flips, then read down to 5.
    for (int i = 1; i <= 16; i++) begin
      ev("fill", (i > 15) ? 15 : i, (i >= 16));
      step();
      if (i >= 3) pop_check();
    end
    step(); pop_check();
    step(); pop_check();
    RD = 1'b1;
    for (int i = 0; i < 10; i++) step();
    RD = 1'b0;
    push("pre_rst", 1'b0, 4'd5, 1'b1, ack_m, 1'b1); pop_check();

    // Reset mid-run discards everything and repeats the lock phase.
    CD = 1'b1; step(); CD = 1'b0;
    ack_m = 1'b0;
    push("mid_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); pop_check();
    TIN = ~TIN;
    step(); step(); step();
    push("lock_absorb", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); pop_check();
    saw_pulse = 1'b0;
    got_lock  = 1'b0;
    for (int i = 0; i < 20 && !got_lock; i++) begin
      step();
      if (PULSE) saw_pulse = 1'b1;
      if (LOCK)  got_lock  = 1'b1;
    end
    chk("relock_reached", 8'(got_lock), 8'd1);
    chk("relock_nopulse", 8'(saw_pulse), 8'd0);
    chk("relock_cnt", 8'(CNT), 8'd0);
    ev("post_lock", 1, 1'b0);
    step(); step(); step(); pop_check();

    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
